// File: rtl/uart_program_loader_pkg.sv
// uart_program_loader_pkg: shared types and constants for the UART program loader.
package uart_program_loader_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CHECK, ST_DONE, ST_ERROR
    } loader_state_e;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    function automatic int bytes_for(input int bits);
        return (bits + 7) / 8;
    endfunction
endpackage

// File: rtl/uart_program_loader_if.sv
// uart_program_loader_if: instruction-memory write port driven by the loader.
interface uart_program_loader_if #(
    parameter int INST_W   = 16,
    parameter int I_ADDR_W = 12
);
    logic                we;
    logic [I_ADDR_W-1:0] addr;
    logic [INST_W-1:0]   wdata;

    modport master (output we, addr, wdata);
    modport slave  (input we, addr, wdata);
endinterface

// File: rtl/uart_program_loader_rx.sv
// uart_rx: 8N1 receiver with 2-FF synchroniser, mid-bit sampling and glitch rejection.
module uart_rx
    import uart_program_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rx,
    output logic                      rx_valid,
    output logic [UART_DATA_BITS-1:0] rx_byte,
    output logic                      rx_frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(UART_DATA_BITS);

    rx_state_e                 state, state_d;
    logic [2:0]                sync;
    logic [CW-1:0]             cnt, cnt_d;
    logic [IW-1:0]             bit_idx, bit_idx_d;
    logic [UART_DATA_BITS-1:0] shift_d;
    logic                      valid_d, err_d, tick_half, tick_full;

    assign tick_half = cnt == CW'(CLKS_PER_BIT / 2 - 1);
    assign tick_full = cnt == CW'(CLKS_PER_BIT - 1);

    // sync[1] is the synchronised line, sync[2] its previous value for edge detection
    always_comb begin
        state_d   = state;
        cnt_d     = cnt + 1'b1;
        bit_idx_d = bit_idx;
        shift_d   = rx_byte;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        case (state)
            RX_IDLE: begin
                cnt_d   = '0;
                state_d = sync[2] && !sync[1] ? RX_START : RX_IDLE;
            end
            RX_START: if (tick_half) begin
                cnt_d     = '0;
                bit_idx_d = '0;
                state_d   = sync[1] ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (tick_full) begin
                cnt_d     = '0;
                shift_d   = {sync[1], rx_byte[UART_DATA_BITS-1:1]};
                bit_idx_d = bit_idx + 1'b1;
                state_d   = bit_idx == IW'(UART_DATA_BITS - 1) ? RX_STOP : RX_DATA;
            end
            RX_STOP: if (tick_full) begin
                cnt_d   = '0;
                valid_d = sync[1];
                err_d   = !sync[1];
                state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync         <= '1;
            state        <= RX_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            rx_byte      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            sync         <= {sync[1:0], rx};
            state        <= state_d;
            cnt          <= cnt_d;
            bit_idx      <= bit_idx_d;
            rx_byte      <= shift_d;
            rx_valid     <= valid_d;
            rx_frame_err <= err_d;
        end
    end
endmodule

// File: rtl/uart_program_loader.sv
// uart_program_loader: UART bootloader writing a checksummed image into instruction memory,
// holding the CPU in reset while loading.
module uart_program_loader
    import uart_program_loader_pkg::*;
#(
    parameter int CLK_FREQ_HZ    = 1_000_000,
    parameter int BAUD_RATE      = 9600,
    parameter int INST_W         = 16,
    parameter int I_ADDR_W       = 12,
    parameter int I_MEMORY_DEPTH = 1 << I_ADDR_W,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  uart_rx,
    output logic                  cpu_run,
    uart_program_loader_if.master imem,
    output logic                  loading,
    output logic                  load_done,
    output logic                  load_error
);
    localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int WB = bytes_for(INST_W);
    localparam int BW = WB > 1 ? $clog2(WB) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    if (CLKS_PER_BIT < 4) begin : g_baud_check
        $error("CLKS_PER_BIT must be at least 4");
    end

    loader_state_e   state, state_d;
    logic            rx_valid, rx_frame_err;
    logic [7:0]      rx_byte, len_lo, sum;
    logic [15:0]     inst_cnt;
    logic [BW-1:0]   byte_idx;
    logic [WB*8-1:0] word, word_d;
    logic [TW-1:0]   idle_cnt;
    logic            idle_like, timeout, too_big, take, last_byte;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (uart_rx),
        .rx_valid     (rx_valid),
        .rx_byte      (rx_byte),
        .rx_frame_err (rx_frame_err)
    );

    assign idle_like = state inside {ST_IDLE, ST_DONE, ST_ERROR};
    assign loading   = !idle_like;
    assign timeout   = loading && !rx_valid && idle_cnt == TW'(TIMEOUT_CYCLES - 1);
    assign too_big   = 32'({rx_byte, len_lo}) * 32'(WB) > 32'(I_MEMORY_DEPTH);
    assign last_byte = byte_idx == BW'(WB - 1);
    assign take      = rx_valid && state == ST_DATA;

    // The final write is followed by one more DATA cycle so the strobe never leaks into CHECK
    always_comb begin
        word_d = word;
        word_d[byte_idx*8 +: 8] = rx_byte;
        state_d = state;
        if (idle_like)
            state_d = rx_valid && rx_byte == SYNC_BYTE ? ST_LEN_LO : state;
        else if (rx_frame_err || timeout)
            state_d = ST_ERROR;
        else
            case (state)
                ST_LEN_LO: state_d = rx_valid ? ST_LEN_HI : state;
                ST_LEN_HI: state_d = !rx_valid ? state : too_big ? ST_ERROR :
                                     {rx_byte, len_lo} == 16'd0 ? ST_CHECK : ST_DATA;
                ST_DATA:   state_d = imem.we && inst_cnt == 16'd0 ? ST_CHECK : state;
                ST_CHECK:  state_d = !rx_valid ? state : rx_byte == sum ? ST_DONE : ST_ERROR;
                default:   state_d = state;
            endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_run    <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            imem.we    <= 1'b0;
            imem.addr  <= '0;
            imem.wdata <= '0;
            len_lo     <= '0;
            sum        <= '0;
            inst_cnt   <= '0;
            byte_idx   <= '0;
            word       <= '0;
            idle_cnt   <= '0;
        end else begin
            load_done <= 1'b0;
            imem.we   <= 1'b0;
            idle_cnt  <= rx_valid || !loading ? '0 : idle_cnt + 1'b1;
            if (imem.we) imem.addr <= imem.addr + I_ADDR_W'(WB);
            if (idle_like && state_d == ST_LEN_LO) begin
                cpu_run    <= 1'b0;
                load_error <= 1'b0;
                imem.addr  <= '0;
                sum        <= '0;
                byte_idx   <= '0;
            end
            if (state == ST_LEN_LO && rx_valid) len_lo <= rx_byte;
            if (state == ST_LEN_HI && rx_valid) inst_cnt <= {rx_byte, len_lo};
            if (take) begin
                sum      <= sum + rx_byte;
                word     <= word_d;
                byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
                if (last_byte) begin
                    imem.we    <= 1'b1;
                    imem.wdata <= word_d[INST_W-1:0];
                    inst_cnt   <= inst_cnt - 1'b1;
                end
            end
            if (state == ST_CHECK && state_d == ST_DONE) begin
                cpu_run   <= 1'b1;
                load_done <= 1'b1;
            end
            if (loading && state_d == ST_ERROR) begin
                cpu_run    <= 1'b0;
                load_error <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// tb_uart_program_loader: scoreboard bench; stimulus pushes expected writes and status
// snapshots, a negedge monitor pops and compares them against the DUT.
module tb_uart_program_loader;
    localparam int CPB     = 16;
    localparam int TIMEOUT = 3000;
    localparam int DEPTH   = 4096;

    typedef struct {
        string name;
        bit    run;
        bit    err;
        bit    ld;
        int    done;
        bit    bus0;
    } st_t;

    logic clk = 1'b0;
    logic rst_n, uart_rx, cpu_run, loading, load_done, load_error;
    int   checks = 0, failures = 0, done_seen = 0, exp_done = 0;
    logic [27:0] exp_wr[$];
    st_t         st_q[$];
    logic [7:0]  d[$];
    logic [7:0]  none[$];
    logic [27:0] w;
    st_t         s;

    always #5 clk = ~clk;

    uart_program_loader_if #(.INST_W(16), .I_ADDR_W(12)) imem();

    uart_program_loader #(
        .CLK_FREQ_HZ    (1_000_000),
        .BAUD_RATE      (62_500),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .uart_rx    (uart_rx),
        .cpu_run    (cpu_run),
        .imem       (imem),
        .loading    (loading),
        .load_done  (load_done),
        .load_error (load_error)
    );

    task automatic cmp(input string nm, input string f, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s.%s got=%0h expected=%0h", nm, f, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (load_done) done_seen++;
        if (imem.we) begin
            checks++;
            if (exp_wr.size() == 0) begin
                failures++;
                $display("FAIL write_unexpected got addr=%h data=%h expected none", imem.addr, imem.wdata);
            end else begin
                w = exp_wr.pop_front();
                if ({imem.addr, imem.wdata} !== w) begin
                    failures++;
                    $display("FAIL write got addr=%h data=%h expected addr=%h data=%h",
                             imem.addr, imem.wdata, w[27:16], w[15:0]);
                end
            end
            cmp("write", "loading", loading, 1);
        end
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            cmp(s.name, "cpu_run", cpu_run, s.run);
            cmp(s.name, "load_error", load_error, s.err);
            cmp(s.name, "loading", loading, s.ld);
            cmp(s.name, "done_count", done_seen, s.done);
            cmp(s.name, "pending_writes", exp_wr.size(), 0);
            if (s.bus0) begin
                cmp(s.name, "imem_we", imem.we, 0);
                cmp(s.name, "imem_addr", imem.addr, 0);
                cmp(s.name, "imem_wdata", imem.wdata, 0);
                cmp(s.name, "load_done", load_done, 0);
            end
        end
    end

    task automatic push_st(input string nm, input bit run, input bit err, input bit ld, input bit bus0);
        st_q.push_back('{nm, run, err, ld, exp_done, bus0});
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(posedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(posedge clk);
        uart_rx = 1'b1;
        repeat (CPB) @(posedge clk);
    endtask

    function automatic logic [7:0] csum(input logic [7:0] q[$]);
        int t = 0;
        foreach (q[i]) t += int'(q[i]);
        return 8'(t % 256);
    endfunction

    task automatic fill(input int nb);
        d.delete();
        repeat (nb) d.push_back(8'($urandom));
    endtask

    // Reference: writes for every complete instruction sent (if the image fits), success only
    // for a complete image whose checksum matches; an unterminated image must time out.
    task automatic run_image(input string nm, input int n, input logic [7:0] q[$],
                             input bit send_cs, input logic [7:0] cs, input bit ferr);
        logic [15:0] nn = 16'(n);
        bit fits = n * 2 <= DEPTH;
        bit good = fits && !ferr && send_cs && q.size() == n * 2 && cs == csum(q);
        send_byte(8'hA5, 1'b1);
        send_byte(nn[7:0], 1'b1);
        send_byte(nn[15:8], 1'b1);
        if (fits) begin
            for (int i = 0; i < q.size(); i++) begin
                if (i % 2 == 1) exp_wr.push_back({12'(i - 1), q[i], q[i-1]});
                send_byte(q[i], 1'b1);
            end
            if (ferr) send_byte(8'h00, 1'b0);
            else if (send_cs) send_byte(cs, 1'b1);
        end
        if (fits && !ferr && !send_cs) repeat (TIMEOUT + 64) @(posedge clk);
        else repeat (4) @(posedge clk);
        if (good) exp_done++;
        push_st(nm, good, !good, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        uart_rx = 1'b1;
        repeat (4) @(posedge clk);
        push_st("reset", 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        send_byte(8'h12, 1'b1);
        send_byte(8'hA5, 1'b0);
        uart_rx = 1'b0;
        repeat (5) @(posedge clk);
        uart_rx = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        push_st("idle_noise", 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);

        d = '{8'h34, 8'h12, 8'h78, 8'h56};
        run_image("basic", 2, d, 1'b1, 8'h14, 1'b0);
        run_image("bad_csum", 2, d, 1'b1, 8'h15, 1'b0);
        fill(6);
        run_image("recover", 3, d, 1'b1, csum(d), 1'b0);
        run_image("empty", 0, none, 1'b1, 8'h00, 1'b0);

        send_byte(8'hA5, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h08, 1'b1);
        repeat (4) @(posedge clk);
        push_st("max_len_data", 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (TIMEOUT + 64) @(posedge clk);
        push_st("max_len_timeout", 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        run_image("len_too_big", 16'h0801, none, 1'b1, 8'h00, 1'b0);

        d = '{8'h34};
        run_image("timeout", 1, d, 1'b0, 8'h00, 1'b0);
        d = '{8'h34, 8'h12, 8'h78};
        run_image("frame_err", 2, d, 1'b0, 8'h00, 1'b1);

        fill(6);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i == 1) exp_wr.push_back({12'h000, d[1], d[0]});
            send_byte(d[i], 1'b1);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        push_st("reset_mid_data", 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (3) @(posedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        run_image("after_reset", 3, d, 1'b1, csum(d), 1'b0);

        for (int k = 0; k < 6; k++) begin
            int n = $urandom_range(1, 5);
            bit bad = $urandom_range(0, 3) == 0;
            fill(2 * n);
            run_image("random", n, d, 1'b1, csum(d) + (bad ? 8'($urandom_range(1, 255)) : 8'h00), 1'b0);
        end

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
Serial bootloader that sits upstream of the CPU's instruction memory and program counter. It receives a framed program image over a UART RX pin and writes it into instruction memory one instruction per write. It holds the CPU core in reset while loading and releases it only after a good checksum. It uses the same clock and reset produced by clk_rst_gen as the rest of the core.

Parameters:
CLK_FREQ_HZ, 1_000_000, core clock frequency (1000 ns period).
BAUD_RATE, 9600, UART bit rate; CLKS_PER_BIT = CLK_FREQ_HZ/BAUD_RATE (integer divide, elaboration-time assert >= 4).
INST_W, 16, instruction width; INST_W_BYTES = ceil(INST_W/8).
I_ADDR_W, 12, instruction byte-address width.
I_MEMORY_DEPTH, 1<<I_ADDR_W, instruction memory size in bytes.
TIMEOUT_CYCLES, 1_000_000, maximum idle clocks between bytes while mid-load.

Ports:
clk  input  1  core clock.
rst_n  input  1  asynchronous, active-low reset.
uart_rx  input  1  asynchronous serial input, idle high.
cpu_run  output  1  1 = CPU may run; 0 = CPU held in reset (ANDed into core reset_n).
imem_we  output  1  single-cycle instruction-memory write strobe.
imem_addr  output  I_ADDR_W  byte address of the instruction being written.
imem_wdata  output  INST_W  instruction word.
loading  output  1  high in any state other than IDLE, DONE or ERROR.
load_done  output  1  one-cycle pulse on a successful load.
load_error  output  1  level; set on failure, cleared by the next sync byte.

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, cpu_run=1, imem_we=0, imem_addr=0, imem_wdata=0, loading=0, load_done=0, load_error=0. Reset mid-load aborts the load. Memory already written stays written.
- UART RX:
  - uart_rx passes through a 2-FF synchroniser.
  - A falling edge starts a frame. The start bit is re-checked at CLKS_PER_BIT/2; if it is high, the frame is dropped as a glitch.
  - Data is then sampled every CLKS_PER_BIT: 8 data bits LSB first, then the stop bit.
  - Stop bit = 1: rx_valid pulses for 1 cycle with rx_byte. Stop bit = 0: rx_frame_err pulses instead.
- Frame format: SYNC (0xA5), LEN_LO, LEN_HI (16-bit instruction count N), then N*INST_W_BYTES data bytes little-endian per instruction, then CSUM.
- CSUM = 8-bit modulo-256 sum of all data bytes.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERROR.
  - IDLE/DONE/ERROR -> LEN_LO on rx_byte==0xA5. On entry to LEN_LO: cpu_run=0 the next cycle, load_error cleared, imem_addr=0, sum=0. Other bytes and framing errors are ignored in these states.
  - LEN_LO -> LEN_HI on the next byte.
  - LEN_HI: if N*INST_W_BYTES > I_MEMORY_DEPTH -> ERROR; if N==0 -> CHECK; else -> DATA.
  - DATA: byte k of an instruction is shifted into bits [8k+7:8k]. After the last byte, imem_we=1 for exactly 1 cycle with the assembled word. imem_addr advances by INST_W_BYTES the cycle after the write. Instruction count decrements; at 0 -> CHECK. Every data byte is added to sum.
  - CHECK: byte==sum -> DONE, with cpu_run=1 and load_done pulsed on entry; otherwise -> ERROR.
  - ERROR: cpu_run=0, load_error=1. Memory is left partially written; no rollback.
- Inter-byte timeout: the counter clears on each rx_valid. In LEN_LO..CHECK it counts up, and reaching TIMEOUT_CYCLES -> ERROR.
- Framing error while loading -> ERROR.
- If rx_frame_err and a timeout occur in the same cycle, the result is ERROR (both lead to the same result).
- imem_we never asserts outside DATA.

Decomposition:
- Package uart_program_loader_pkg:
  - loader_state_e enum.
  - SYNC_BYTE = 8'hA5.
  - UART_DATA_BITS = 8.
- Sub-module uart_rx (synchroniser, bit timer, shift register; outputs rx_valid, rx_byte, rx_frame_err) instantiated once inside. The loader FSM lives in the top module.

Test Plan:
1. Reset, then send A5 02 00 34 12 78 56 14 -> writes (addr 0x000, 0x1234) then (0x002, 0x5678), one imem_we cycle each; load_done pulses once; cpu_run returns to 1; load_error=0.
2. Same image with CSUM=0x15 -> both writes occur; state ERROR; cpu_run=0, load_error=1. A following good image clears load_error and ends with cpu_run=1.
3. Send A5 00 08 (2048 instructions * 2 bytes = 4096 bytes, which fits the default depth) vs A5 01 08 (4098 bytes) -> the first enters DATA; the second goes straight to ERROR with no imem_we.
4. Send A5 01 00 34, then idle for TIMEOUT_CYCLES -> ERROR with no write. A 0x00 stop-bit framing error mid-DATA also -> ERROR.
5. In IDLE, send 0x12, a 0xA5 byte with a bad stop bit, and a 0.3-bit low glitch -> no state change; cpu_run stays 1.
6. Assert rst_n=0 mid-DATA -> all outputs return to reset values immediately; a subsequent full image loads correctly from addr 0.
